data_mem_responder: RTL and testbench

- Responder (memory side) for the RV32I core's data-memory load/store request channel.
- Accepts one request at a time over a valid/ready handshake and applies a programmable number of wait states.
- Performs byte, half-word or word access on a little-endian word array, with sign/zero extension on loads.
- Returns read data and an error flag over a valid/ready response channel.

---
 rtl/data_mem_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the RV32I data load/store channel. One request is
// accepted at a time over a valid/ready handshake. After a programmable number
// of wait states, the access is performed on a little-endian word array. Loads
// are sign- or zero-extended. Read data and an error flag are returned over a
// valid/ready response channel.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 4)
//   WAIT_CYCLES : wait states between accept and response (0..15)
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : request present
//   req_ready  : responder can accept (high only while idle)
//   req_write  : 1 = store, 0 = load
//   req_addr   : byte address
//   req_funct3 : RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_wdata  : store data, right-aligned
//   rsp_valid  : response present
//   rsp_ready  : core accepts response
//   rsp_rdata  : extended load result; 0 for stores and faults
//   rsp_error  : access faulted; memory was not modified
//   err_count  : (only with DMEM_ERR_COUNT_EN) saturating count of faulted
//                responses handed over to the core
//
// Optional feature macro: DMEM_ERR_COUNT_EN
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
`ifdef DMEM_ERR_COUNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          write_q;
    logic [31:0]   addr_q;
    logic [2:0]    funct3_q;
    logic [31:0]   wdata_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_error_q;

    // Word array and its registered read port.
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   rd_word_q;

    logic          accept;
    logic          access;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;

    logic          err_d;
    logic [31:0]   shifted_d;
    logic [7:0]    byte_d;
    logic [15:0]   half_d;
    logic [31:0]   load_d;
    logic [31:0]   rsp_rdata_d;
    logic [3:0]    be_d;
    logic [31:0]   wr_aligned_d;
    logic [31:0]   wr_word_d;

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

    assign accept   = (state_q == S_IDLE) && req_valid;
    // Access happens on the final wait edge, once the counter has run out.
    assign access   = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign req_idx  = req_addr[AW+1:2];
    assign word_idx = addr_q[AW+1:2];
    assign lane     = addr_q[1:0];

    // Fault detection on the latched request.
    always_comb begin
        err_d = 1'b0;
        case (funct3_q)
            3'b000:  err_d = 1'b0;
            3'b001:  err_d = addr_q[0];
            3'b010:  err_d = |addr_q[1:0];
            3'b100:  err_d = write_q;              // no unsigned store forms
            3'b101:  err_d = write_q | addr_q[0];
            default: err_d = 1'b1;
        endcase
        if (|addr_q[31:AW+2]) begin
            err_d = 1'b1;                          // beyond the array
        end
    end

    // Load lane selection and extension.
    always_comb begin
        shifted_d = rd_word_q >> {lane, 3'b000};
        byte_d    = shifted_d[7:0];
        half_d    = addr_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        case (funct3_q)
            3'b000:  load_d = {{24{byte_d[7]}}, byte_d};
            3'b001:  load_d = {{16{half_d[15]}}, half_d};
            3'b010:  load_d = rd_word_q;
            3'b100:  load_d = {24'd0, byte_d};
            3'b101:  load_d = {16'd0, half_d};
            default: load_d = 32'd0;
        endcase
        rsp_rdata_d = (err_d || write_q) ? 32'd0 : load_d;
    end

    // Store byte enables; data is replicated so every lane sees its bits.
    always_comb begin
        be_d         = 4'b0000;
        wr_aligned_d = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                be_d[lane]   = 1'b1;
                wr_aligned_d = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_d         = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_aligned_d = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                be_d = 4'b1111;
            end
            default: be_d = 4'b0000;
        endcase
    end

    // Merge enabled lanes into the word fetched at accept time. The word
    // cannot change in between because only one access is ever in flight.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wr_word_d[8*gi +: 8] = be_d[gi] ? wr_aligned_d[8*gi +: 8]
                                               : rd_word_q[8*gi +: 8];
    end

    // Array port: read addressed straight from the request at accept, full
    // word write-back at the access edge. Contents survive reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word_q <= mem_q[req_idx];
        end
        if (access && write_q && !err_d) begin
            mem_q[word_idx] <= wr_word_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            addr_q      <= 32'd0;
            funct3_q    <= 3'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_error_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        addr_q   <= req_addr;
                        funct3_q <= req_funct3;
                        wdata_q  <= req_wdata;
                        cnt_q    <= WAIT_INIT;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_error_q <= err_d;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_error_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef DMEM_ERR_COUNT_EN
    logic [15:0] err_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= 16'd0;
        end else if (rsp_valid_q && rsp_ready && rsp_error_q &&
                     (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Two responder instances share the clock and reset:
//   k=0 : DEPTH_WORDS=1024, WAIT_CYCLES=1
//   k=1 : DEPTH_WORDS=16,   WAIT_CYCLES=0
// Directed table vectors, hand-written multi-cycle sequences (held response,
// reset during a wait) and random traffic checked against a byte-array model.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid_v  [2];
    logic        req_ready_v  [2];
    logic        req_write_v  [2];
    logic [31:0] req_addr_v   [2];
    logic [2:0]  req_funct3_v [2];
    logic [31:0] req_wdata_v  [2];
    logic        rsp_valid_v  [2];
    logic        rsp_ready_v  [2];
    logic [31:0] rsp_rdata_v  [2];
    logic        rsp_error_v  [2];
`ifdef DMEM_ERR_COUNT_EN
    logic [15:0] err_count_v  [2];
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int exp_cnt [2];

    logic [7:0] mem_m [2][4096];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        data_mem_responder #(
            .DEPTH_WORDS((gi == 0) ? 1024 : 16),
            .WAIT_CYCLES((gi == 0) ? 1 : 0)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid_v[gi]),
            .req_ready  (req_ready_v[gi]),
            .req_write  (req_write_v[gi]),
            .req_addr   (req_addr_v[gi]),
            .req_funct3 (req_funct3_v[gi]),
            .req_wdata  (req_wdata_v[gi]),
            .rsp_valid  (rsp_valid_v[gi]),
            .rsp_ready  (rsp_ready_v[gi]),
            .rsp_rdata  (rsp_rdata_v[gi]),
            .rsp_error  (rsp_error_v[gi])
`ifdef DMEM_ERR_COUNT_EN
            ,
            .err_count  (err_count_v[gi])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int depth_of(input int k);
        return (k == 0) ? 1024 : 16;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, faults derived from access size.
    task automatic model(input int k, input logic w, input logic [31:0] a,
                         input logic [2:0] f, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
        int size;
        logic [31:0] val;
        size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        er = 1'b0;
        rd = 32'd0;
        if (f == 3'd3 || f == 3'd6 || f == 3'd7) er = 1'b1;
        if (w && f >= 3'd4) er = 1'b1;
        if (longint'(a) >= longint'(depth_of(k)) * 4) er = 1'b1;
        if (!er && (a % size) != 0) er = 1'b1;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < size; i++) mem_m[k][int'(a) + i] = wd[8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < size; i++) val = val | (32'(mem_m[k][int'(a) + i]) << (8*i));
                if (f == 3'd0 && val[7])  val = val | 32'hFFFFFF00;
                if (f == 3'd1 && val[15]) val = val | 32'hFFFF0000;
                rd = val;
            end
        end
    endtask

    // One full transaction. hold = cycles rsp_ready stays low after rsp_valid;
    // pre = rsp_ready already high before the response appears.
    task automatic txn(input int k, input logic w, input logic [31:0] a,
                       input logic [2:0] f, input logic [31:0] wd,
                       input int hold, input logic pre,
                       input logic [31:0] exp_rd, input logic exp_er,
                       input string tag);
        int n;
        logic [31:0] rd;
        logic er;
        req_valid_v[k]  = 1'b1;
        req_write_v[k]  = w;
        req_addr_v[k]   = a;
        req_funct3_v[k] = f;
        req_wdata_v[k]  = wd;
        chk({tag, " req_ready_idle"}, 32'(req_ready_v[k]), 32'd1);
        @(posedge clk); #1;
        // Scramble the channel: the in-flight access must use latched fields.
        req_valid_v[k]  = 1'b0;
        req_write_v[k]  = ~w;
        req_addr_v[k]   = $urandom;
        req_funct3_v[k] = 3'($urandom);
        req_wdata_v[k]  = $urandom;
        rsp_ready_v[k]  = pre;
        n = 0;
        while (!rsp_valid_v[k] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), (k == 0) ? 32'd2 : 32'd1);
        rd = rsp_rdata_v[k];
        er = rsp_error_v[k];
        chk({tag, " rdata"}, rd, exp_rd);
        chk({tag, " error"}, 32'(er), 32'(exp_er));
        if (!pre) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk({tag, " hold_valid"}, 32'(rsp_valid_v[k]), 32'd1);
                chk({tag, " hold_rdata"}, rsp_rdata_v[k], rd);
                chk({tag, " hold_error"}, 32'(rsp_error_v[k]), 32'(er));
                chk({tag, " hold_req_ready"}, 32'(req_ready_v[k]), 32'd0);
            end
        end
        rsp_ready_v[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready_v[k] = 1'b0;
        chk({tag, " valid_drop"}, 32'(rsp_valid_v[k]), 32'd0);
        chk({tag, " ready_back"}, 32'(req_ready_v[k]), 32'd1);
        if (exp_er) exp_cnt[k]++;
`ifdef DMEM_ERR_COUNT_EN
        chk({tag, " err_count"}, 32'(err_count_v[k]), 32'(exp_cnt[k]));
`endif
        $display("txn %s k=%0d %s a=%h f3=%b wd=%h -> rd=%h err=%0d lat=%0d",
                 tag, k, w ? "ST" : "LD", a, f, wd, rd, er, n);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [2:0]  f;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] m_rd;
        logic        m_er;
        logic        w;
        logic [31:0] a;
        logic [2:0]  f;
        logic [31:0] wd;
        int          k;

        vecs.push_back('{1'b1, 32'h10,   3'b010, 32'hDEADBEEF, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 32'h10,   3'b010, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h11,   3'b000, 32'h00000055, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 32'h10,   3'b010, 32'h0,        32'hDEAD55EF, 1'b0});
        vecs.push_back('{1'b0, 32'h13,   3'b000, 32'h0,        32'hFFFFFFDE, 1'b0});
        vecs.push_back('{1'b0, 32'h13,   3'b100, 32'h0,        32'h000000DE, 1'b0});
        vecs.push_back('{1'b0, 32'h12,   3'b001, 32'h0,        32'hFFFFDEAD, 1'b0});
        vecs.push_back('{1'b0, 32'h12,   3'b101, 32'h0,        32'h0000DEAD, 1'b0});
        vecs.push_back('{1'b0, 32'h10,   3'b000, 32'h0,        32'hFFFFFFEF, 1'b0});
        vecs.push_back('{1'b0, 32'h10,   3'b001, 32'h0,        32'h000055EF, 1'b0});
        vecs.push_back('{1'b0, 32'h12,   3'b010, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 32'h11,   3'b001, 32'h0000FFFF, 32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 32'h1000, 3'b010, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 32'h10,   3'b011, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 32'h10,   3'b100, 32'h000000AA, 32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 32'h10,   3'b010, 32'h0,        32'hDEAD55EF, 1'b0});
        vecs.push_back('{1'b1, 32'h20,   3'b010, 32'hA5A50F0F, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 32'h20,   3'b010, 32'h0,        32'hA5A50F0F, 1'b0});

        for (int i = 0; i < 2; i++) begin
            req_valid_v[i] = 1'b0; req_write_v[i] = 1'b0; req_addr_v[i] = 32'd0;
            req_funct3_v[i] = 3'd0; req_wdata_v[i] = 32'd0; rsp_ready_v[i] = 1'b0;
            exp_cnt[i] = 0;
        end

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset rsp_valid", 32'(rsp_valid_v[i]), 32'd0);
            chk("reset rsp_rdata", rsp_rdata_v[i], 32'd0);
            chk("reset rsp_error", 32'(rsp_error_v[i]), 32'd0);
`ifdef DMEM_ERR_COUNT_EN
            chk("reset err_count", 32'(err_count_v[i]), 32'd0);
`endif
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) chk("reset req_ready", 32'(req_ready_v[i]), 32'd1);

        // Fill the regions used later so the model and array start identical.
        for (int kk = 0; kk < 2; kk++) begin
            for (int wi = 0; wi < ((kk == 0) ? 64 : 16); wi++) begin
                wd = $urandom;
                model(kk, 1'b1, 32'(wi * 4), 3'b010, wd, m_rd, m_er);
                txn(kk, 1'b1, 32'(wi * 4), 3'b010, wd, 0, 1'b0, m_rd, m_er, "init");
            end
        end

        // Directed table.
        foreach (vecs[i]) begin
            model(0, vecs[i].w, vecs[i].a, vecs[i].f, vecs[i].wd, m_rd, m_er);
            txn(0, vecs[i].w, vecs[i].a, vecs[i].f, vecs[i].wd, 0, 1'b0,
                vecs[i].rd, vecs[i].er, $sformatf("vec%0d", i));
        end

        // Response held for 5 cycles with rsp_ready low.
        txn(0, 1'b0, 32'h10, 3'b010, 32'h0, 5, 1'b0, 32'hDEAD55EF, 1'b0, "hold");

        // Reset while the store to 0x20 is still waiting.
        req_valid_v[0] = 1'b1; req_write_v[0] = 1'b1; req_addr_v[0] = 32'h20;
        req_funct3_v[0] = 3'b010; req_wdata_v[0] = 32'h12345678;
        @(posedge clk); #1;
        req_valid_v[0] = 1'b0;
        chk("midrst in_wait req_ready", 32'(req_ready_v[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst rsp_valid", 32'(rsp_valid_v[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        @(posedge clk); #1;
        chk("midrst req_ready", 32'(req_ready_v[0]), 32'd1);
        chk("midrst rsp_valid_after", 32'(rsp_valid_v[0]), 32'd0);
        model(0, 1'b0, 32'h20, 3'b010, 32'h0, m_rd, m_er);
        txn(0, 1'b0, 32'h20, 3'b010, 32'h0, 0, 1'b0, m_rd, m_er, "midrst_lw");

        // Three faults on the zero-wait instance, then a clean load.
        txn(1, 1'b0, 32'h6, 3'b010, 32'h0, 0, 1'b0, 32'h0, 1'b1, "z_misw");
        txn(1, 1'b1, 32'h40, 3'b010, 32'h1, 0, 1'b1, 32'h0, 1'b1, "z_oob");
        txn(1, 1'b0, 32'h3, 3'b101, 32'h0, 1, 1'b0, 32'h0, 1'b1, "z_mish");
        model(1, 1'b0, 32'h3C, 3'b010, 32'h0, m_rd, m_er);
        txn(1, 1'b0, 32'h3C, 3'b010, 32'h0, 0, 1'b1, m_rd, m_er, "z_lw");

        // Random traffic against the model.
        for (int i = 0; i < 160; i++) begin
            k  = i % 2;
            w  = 1'($urandom_range(0, 1));
            f  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if ($urandom_range(0, 9) == 0)
                a = ($urandom_range(0, 1) == 0) ? 32'(depth_of(k) * 4 + $urandom_range(0, 15))
                                                : ($urandom | 32'h80000000);
            else
                a = 32'($urandom_range(0, (k == 0) ? 255 : 63));
            model(k, w, a, f, wd, m_rd, m_er);
            txn(k, w, a, f, wd, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                m_rd, m_er, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
